// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - shared types and constants for the button conditioning stage
package cond_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM_HIGH,
        ST_HELD,
        ST_REPEAT,
        ST_ARM_LOW
    } cond_state_t;

    localparam int PRESS_CNT_W = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cond_sync.sv
// rtl/cond_sync.sv - multi-flop synchronizer for an asynchronous level input
module cond_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cond_debounce.sv
// rtl/cond_debounce.sv - synchronize, debounce and auto-repeat a push-button into a one-cycle strobe
module cond_debounce
    import cond_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   btn_i,
    output logic                   cond_o,
    output logic                   level_o,
    output logic [PRESS_CNT_W-1:0] press_cnt_o
);

    localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DEB_C = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] DLY_C = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] PER_C = CNT_W'(REPEAT_PERIOD);

    logic                   btn_s;
    cond_state_t            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                   cond_q, cond_d;
    logic                   level_q, level_d;
    logic [PRESS_CNT_W-1:0] press_q, press_d;

    cond_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .d_i    (btn_i),
        .q_o    (btn_s)
    );

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cond_q  <= 1'b0;
            level_q <= 1'b0;
            press_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cond_q  <= cond_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cond_d  = 1'b0;
        level_d = level_q;
        press_d = press_q;

        unique case (state_q)
            // IDLE always holds a zero count, so its first high sample counts as one
            ST_IDLE, ST_ARM_HIGH: begin
                if (!btn_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_inc == DEB_C) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                    cond_d  = 1'b1;
                    level_d = 1'b1;
                    press_d = press_q + PRESS_CNT_W'(1);
                end else begin
                    state_d = ST_ARM_HIGH;
                    cnt_d   = cnt_inc;
                end
            end

            // Release wins over any repeat expiry; the first low sample already counts
            ST_HELD, ST_REPEAT: begin
                if (!btn_s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        level_d = 1'b0;
                    end else begin
                        state_d = ST_ARM_LOW;
                        cnt_d   = CNT_W'(1);
                    end
                end else if (state_q == ST_HELD) begin
                    if (REPEAT_DELAY != 0) begin
                        if (cnt_q == DLY_C) begin
                            state_d = ST_REPEAT;
                            cnt_d   = '0;
                            cond_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end else begin
                    if (cnt_q == PER_C) begin
                        cnt_d  = '0;
                        cond_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end

            ST_ARM_LOW: begin
                if (btn_s) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_inc == DEB_C) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    assign cond_o      = cond_q;
    assign level_o     = level_q;
    assign press_cnt_o = press_q;

endmodule

// File: tb/tb_cond_debounce.sv
// tb/tb_cond_debounce.sv - self-checking bench for cond_debounce against a behavioural model
module tb_cond_debounce;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int DLY  = 8;
    localparam int PER  = 3;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       btn_i = 1'b0;
    logic       cond_o;
    logic       level_o;
    logic [7:0] press_cnt_o;

    cond_debounce #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (DLY),
        .REPEAT_PERIOD  (PER)
    ) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .btn_i      (btn_i),
        .cond_o     (cond_o),
        .level_o    (level_o),
        .press_cnt_o(press_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int pulse_log[$];

    // Model state: delay line for the synchronizer, debounced level, run length of
    // disagreeing samples, cycles since the press/return reference, and a "was low" flag.
    logic m_sync[SYNC];
    logic m_lvl;
    logic m_pulse;
    int   m_run;
    int   m_t;
    bit   m_wlow;
    int   m_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
        m_lvl = 1'b0; m_pulse = 1'b0; m_run = 0; m_t = 0; m_wlow = 0; m_pc = 0;
    endtask

    task automatic model_edge(input logic b);
        logic bs;
        bs = m_sync[SYNC-1];
        for (int i = SYNC-1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = b;
        m_pulse = 1'b0;
        if (bs != m_lvl) begin
            m_run++;
            if (m_lvl) m_wlow = 1;
            if (m_run == DEB) begin
                m_lvl  = ~m_lvl;
                m_run  = 0;
                m_wlow = 0;
                if (m_lvl) begin
                    m_pulse = 1'b1;
                    m_pc    = (m_pc + 1) % 256;
                    m_t     = 0;
                end
            end
        end else begin
            m_run = 0;
            if (m_lvl) begin
                if (m_wlow) begin
                    m_t = 0;
                    m_wlow = 0;
                end else begin
                    m_t++;
                    if (DLY != 0 && m_t >= DLY + 1 && ((m_t - DLY - 1) % (PER + 1)) == 0)
                        m_pulse = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_outputs();
        check("cond_o", 32'(cond_o), 32'(m_pulse));
        check("level_o", 32'(level_o), 32'(m_lvl));
        check("press_cnt_o", 32'(press_cnt_o), 32'(m_pc));
        if (cond_o === 1'b1) pulse_log.push_back(cyc);
    endtask

    task automatic step(input logic b);
        btn_i = b;
        @(posedge clk_i);
        model_edge(b);
        cyc++;
        #1;
        compare_outputs();
    endtask

    task automatic reset_step(input logic b);
        btn_i   = b;
        reset_i = 1'b1;
        @(posedge clk_i);
        model_reset();
        cyc++;
        #1;
        reset_i = 1'b0;
        compare_outputs();
    endtask

    function automatic int count_since(input int base);
        int n = 0;
        foreach (pulse_log[i]) if (pulse_log[i] > base) n++;
        return n;
    endfunction

    function automatic int nth_since(input int base, input int k);
        int n = 0;
        foreach (pulse_log[i]) begin
            if (pulse_log[i] > base) begin
                if (n == k) return pulse_log[i] - base;
                n++;
            end
        end
        return -1;
    endfunction

    initial begin
        int base;
        int exp_rep[6];
        exp_rep = '{6, 15, 19, 23, 27, 31};
        model_reset();

        // Reset state
        reset_step(1'b0);
        reset_step(1'b0);

        // Clean press
        base = cyc;
        repeat (10) step(1'b1);
        check("clean_count", 32'(count_since(base)), 32'd1);
        check("clean_edge", 32'(nth_since(base, 0)), 32'd6);
        check("clean_level", 32'(level_o), 32'd1);
        check("clean_press_cnt", 32'(press_cnt_o), 32'd1);
        repeat (8) step(1'b0);
        check("clean_release", 32'(level_o), 32'd0);

        // Glitch bursts never qualify
        base = cyc;
        repeat (5) begin
            repeat (3) step(1'b1);
            step(1'b0);
        end
        check("glitch_count", 32'(count_since(base)), 32'd0);
        check("glitch_level", 32'(level_o), 32'd0);
        repeat (4) step(1'b0);

        // Auto-repeat
        base = cyc;
        repeat (31) step(1'b1);
        check("repeat_count", 32'(count_since(base)), 32'd6);
        for (int i = 0; i < 6; i++)
            check($sformatf("repeat_edge%0d", i), 32'(nth_since(base, i)), 32'(exp_rep[i]));
        check("repeat_press_cnt", 32'(press_cnt_o), 32'd2);
        repeat (8) step(1'b0);

        // Release bounce: 2-cycle dip restarts the repeat delay
        base = cyc;
        repeat (10) step(1'b1);
        repeat (2) step(1'b0);
        repeat (14) step(1'b1);
        check("bounce_count", 32'(count_since(base)), 32'd2);
        check("bounce_repeat_edge", 32'(nth_since(base, 1)), 32'd24);
        check("bounce_level", 32'(level_o), 32'd1);
        check("bounce_press_cnt", 32'(press_cnt_o), 32'd3);
        repeat (8) step(1'b0);

        // Wrap: 256 presses from a cleared counter
        reset_step(1'b0);
        base = cyc;
        repeat (256) begin
            repeat ($urandom_range(9, 6)) step(1'b1);
            repeat ($urandom_range(9, 6)) step(1'b0);
        end
        check("wrap_pulses", 32'(count_since(base)), 32'd256);
        check("wrap_press_cnt", 32'(press_cnt_o), 32'd0);

        // Reset mid-hold, then a fresh full debounce
        repeat (19) step(1'b1);
        reset_step(1'b1);
        check("rst_cond", 32'(cond_o), 32'd0);
        check("rst_level", 32'(level_o), 32'd0);
        check("rst_press_cnt", 32'(press_cnt_o), 32'd0);
        base = cyc;
        repeat (10) step(1'b1);
        check("rst_repress_count", 32'(count_since(base)), 32'd1);
        check("rst_repress_edge", 32'(nth_since(base, 0)), 32'd6);
        check("rst_repress_cnt", 32'(press_cnt_o), 32'd1);

        // Random run lengths, including glitches, repeats and bounces
        repeat (300) begin
            logic lv;
            lv = 1'($urandom_range(1, 0));
            repeat ($urandom_range(24, 1)) step(lv);
        end
        repeat (10) step(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
